imem_loader: RTL and testbench

Byte-stream loader that fills the writable instruction memory before the core runs. It accepts a count of 32-bit words, then takes bytes over a valid/ready stream. Each byte is written to consecutive byte addresses in little-endian word order, the same byte layout the instruction memory read port reassembles. While loading, it holds the core stalled and keeps a running 32-bit checksum of the assembled words.

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Byte-stream loader for the writable instruction memory. Takes a
//            word count, accepts bytes over valid/ready, writes them to
//            consecutive byte addresses (little-endian within each word),
//            holds the core stalled and keeps a running word checksum.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 128,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       word_count,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Bounds are compared in a wide domain so BASE_ADDR + total never wraps.
  localparam logic [39:0]       c_base_w  = 40'(BASE_ADDR);
  localparam logic [39:0]       c_depth_w = 40'(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] c_base_a  = ADDR_W'(BASE_ADDR);

  state_t            r_state;
  state_t            w_next;
  logic [17:0]       r_byte_cnt;
  logic [17:0]       r_total;
  logic [23:0]       r_word;
  logic [31:0]       r_checksum;
  logic              r_err;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_waddr;
  logic [7:0]        r_mem_wdata;

  logic [17:0]       w_total;
  logic [39:0]       w_end;
  logic              w_fits;
  logic              w_accept;
  logic              w_hs;
  logic              w_last;

  assign w_total  = {word_count, 2'b00};
  assign w_end    = c_base_w + {22'd0, w_total};
  assign w_fits   = (w_end <= c_depth_w);
  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_hs     = (r_state == ST_LOAD) && s_valid;
  assign w_last   = w_hs && (r_byte_cnt == (r_total - 18'd1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and state-derived handshake/status outputs.
  always_comb begin
    w_next   = r_state;
    s_ready  = 1'b0;
    cpu_hold = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && w_fits) w_next = (w_total == 18'd0) ? ST_FIN : ST_LOAD;
      end
      ST_LOAD: begin
        s_ready  = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (w_last) w_next = ST_FIN;
      end
      ST_FIN: begin
        done     = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Session setup, registered memory write port, word assembly and checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt  <= 18'd0;
      r_total     <= 18'd0;
      r_word      <= 24'd0;
      r_checksum  <= 32'd0;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= 8'd0;
    end else begin
      r_mem_we <= w_hs;
      if (w_accept) begin
        if (!w_fits) begin
          r_err <= 1'b1;
        end else begin
          r_err      <= 1'b0;
          r_checksum <= 32'd0;
          r_byte_cnt <= 18'd0;
          r_total    <= w_total;
        end
      end
      if (w_hs) begin
        r_mem_waddr <= c_base_a + ADDR_W'(r_byte_cnt);
        r_mem_wdata <= s_data;
        r_byte_cnt  <= r_byte_cnt + 18'd1;
        case (r_byte_cnt[1:0])
          2'd0:    r_word[7:0]   <= s_data;
          2'd1:    r_word[15:8]  <= s_data;
          2'd2:    r_word[23:16] <= s_data;
          default: r_checksum    <= r_checksum + {s_data, r_word};
        endcase
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_waddr = r_mem_waddr;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;
  assign checksum  = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Self-checking bench for imem_loader with a queue-based reference
//            model of the byte stream, write addresses and word checksum.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] word_count;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;

  int n_cmp = 0;
  int n_bad = 0;
  byte unsigned tx[$];

  imem_loader #(.ADDR_W(32), .DEPTH_BYTES(128), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference checksum: sum of little-endian words of the first n bytes.
  function automatic logic [31:0] ref_sum(input int n);
    logic [31:0] s = 32'd0;
    for (int w = 0; w < n / 4; w++)
      s = s + {tx[4*w+3], tx[4*w+2], tx[4*w+1], tx[4*w]};
    return s;
  endfunction

  // One full session; gap: 0 = valid held high, 1 = alternate, 2 = random.
  task automatic do_load(input int wc, input int gap, input bit pulse_start);
    int total = wc * 4;
    int i = 0;
    int cyc = 0;
    int nwr = 0;
    bit v;
    start = 1'b1; word_count = 16'(wc);
    step();
    start = 1'b0;
    chk("err_clear", {31'd0, err}, 32'd0);
    chk("busy_load", {31'd0, busy}, 32'd1);
    while (i < total && cyc < 2000) begin
      chk("s_ready_load", {31'd0, s_ready}, 32'd1);
      chk("hold_load", {31'd0, cpu_hold}, 32'd1);
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      s_valid = v;
      s_data  = tx[i];
      if (pulse_start && cyc == 2) begin start = 1'b1; word_count = 16'd5; end
      step();
      start = 1'b0;
      cyc++;
      if (mem_we) nwr++;
      if (v) begin
        chk("we", {31'd0, mem_we}, 32'd1);
        chk("waddr", mem_waddr, 32'(i));
        chk("wdata", {24'd0, mem_wdata}, {24'd0, tx[i]});
        chk("done_last", {31'd0, done}, (i == total - 1) ? 32'd1 : 32'd0);
        i++;
        if (i % 4 == 0) chk("sum_partial", checksum, ref_sum(i));
      end else begin
        chk("we_gap", {31'd0, mem_we}, 32'd0);
        chk("done_gap", {31'd0, done}, 32'd0);
      end
    end
    s_valid = 1'b0;
    if (cyc >= 2000) chk("load_timeout", 32'd1, 32'd0);
    chk("fin_s_ready", {31'd0, s_ready}, 32'd0);
    chk("fin_hold", {31'd0, cpu_hold}, 32'd1);
    chk("sum_final", checksum, ref_sum(total));
    chk("write_count", 32'(nwr), 32'(total));
    step();
    chk("idle_hold", {31'd0, cpu_hold}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_we", {31'd0, mem_we}, 32'd0);
    chk("sum_hold", checksum, ref_sum(total));
  endtask

  task automatic fill_random(input int nbytes);
    tx.delete();
    for (int k = 0; k < nbytes; k++) tx.push_back(byte'($urandom_range(0, 255)));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_waddr"}, mem_waddr, 32'd0);
    chk({tag, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_sum"}, checksum, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; word_count = 16'd0; s_data = 8'd0; s_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Directed 2-word load, valid held high, then the same with gaps.
    tx = '{8'h33, 8'h81, 8'h20, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00};
    do_load(2, 0, 1'b0);
    chk("sum_dir", checksum, 32'h0020_8166);
    do_load(2, 1, 1'b0);
    chk("sum_gap", checksum, 32'h0020_8166);

    // Zero-word load: one FIN cycle, no write.
    start = 1'b1; word_count = 16'd0;
    step();
    start = 1'b0;
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_we", {31'd0, mem_we}, 32'd0);
    chk("zero_sum", checksum, 32'd0);
    chk("zero_err", {31'd0, err}, 32'd0);
    step();
    chk("zero_idle_done", {31'd0, done}, 32'd0);
    chk("zero_idle_busy", {31'd0, busy}, 32'd0);
    chk("zero_idle_we", {31'd0, mem_we}, 32'd0);

    // Overflow: 33 words do not fit in 128 bytes.
    start = 1'b1; word_count = 16'd33;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("ovf_err", {31'd0, err}, 32'd1);
      chk("ovf_busy", {31'd0, busy}, 32'd0);
      chk("ovf_s_ready", {31'd0, s_ready}, 32'd0);
      chk("ovf_we", {31'd0, mem_we}, 32'd0);
      step();
    end
    fill_random(4);
    do_load(1, 0, 1'b0);

    // Reset after 3 accepted bytes, then a fresh load from address 0.
    fill_random(8);
    start = 1'b1; word_count = 16'd2;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = tx[k];
      step();
    end
    s_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    do_load(2, 0, 1'b0);

    // Start pulsed during LOAD is ignored; checksum wraps.
    tx = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    do_load(2, 0, 1'b1);
    chk("sum_wrap", checksum, 32'h0000_0001);

    // Full-depth boundary load: 32 words exactly fill memory.
    fill_random(128);
    do_load(32, 2, 1'b0);

    // Randomized sessions.
    for (int r = 0; r < 8; r++) begin
      int wc;
      wc = $urandom_range(1, 32);
      fill_random(wc * 4);
      do_load(wc, 2, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
